// File: rtl/seq_magnitude_compare_pkg.sv
// Shared encodings for the slice-serial magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // RES_NONE marks "no result yet": after reset, and while a compare is running
  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_LT   = 2'd1;
  localparam logic [1:0] RES_EQ   = 2'd2;
  localparam logic [1:0] RES_GT   = 2'd3;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_magnitude_compare_slice_compare.sv
// Combinational SLICE-bit compare; msb_invert maps a signed top slice to offset binary.
module slice_compare #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             msb_invert,
  output logic             gt,
  output logic             eq
);

  logic [SLICE-1:0] flip;

  assign flip = msb_invert ? (SLICE'(1) << (SLICE - 1)) : '0;

  always_comb begin
    gt = 1'b0;
    eq = 1'b0;
    if ((a ^ flip) > (b ^ flip)) begin
      gt = 1'b1;
    end else if (a == b) begin
      eq = 1'b1;
    end
  end

endmodule

// File: rtl/seq_magnitude_compare.sv
// Multi-cycle magnitude comparator, MSB slice first with early exit.
// state | meaning: IDLE ready for start | BUSY comparing slice idx | DONE one-clock result strobe
module seq_magnitude_compare
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = idx_width(NSLICE);

  if ((WIDTH % SLICE) != 0 || NSLICE < 1) begin : g_width_check
    $error("seq_magnitude_compare: WIDTH must be a non-zero multiple of SLICE");
  end

  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sm_q;
  logic [IW-1:0]    idx, idx_n;
  logic [1:0]       res, res_n;
  logic             load;

  logic [SLICE-1:0] a_slice, b_slice;
  logic             msb_invert;
  logic             s_gt, s_eq;

  assign a_slice    = a_q[idx*SLICE +: SLICE];
  assign b_slice    = b_q[idx*SLICE +: SLICE];
  assign msb_invert = sm_q && (idx == IW'(NSLICE - 1));

  slice_compare #(.SLICE(SLICE)) u_slice_compare (
    .a          (a_slice),
    .b          (b_slice),
    .msb_invert (msb_invert),
    .gt         (s_gt),
    .eq         (s_eq)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
      res   <= RES_NONE;
      a_q   <= '0;
      b_q   <= '0;
      sm_q  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      res   <= res_n;
      if (load) begin
        a_q  <= a;
        b_q  <= b;
        sm_q <= signed_mode;
      end
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    res_n   = res;
    load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          idx_n   = IW'(NSLICE - 1);
          res_n   = RES_NONE;
          state_n = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!s_eq) begin
          res_n   = s_gt ? RES_GT : RES_LT;
          state_n = ST_DONE;
        end else if (idx == '0) begin
          res_n   = RES_EQ;
          state_n = ST_DONE;
        end else begin
          idx_n = idx - 1'b1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign ready = (state == ST_IDLE);
  assign done  = (state == ST_DONE);
  assign gt    = (res == RES_GT);
  assign eq    = (res == RES_EQ);
  assign lt    = (res == RES_LT);

endmodule

// File: tb/tb_seq_magnitude_compare.sv
// Directed and randomized bench for seq_magnitude_compare (WIDTH=32, SLICE=8).
module tb_seq_magnitude_compare;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             ready, done, gt, eq, lt;

  int checks = 0;
  int errors = 0;

  seq_magnitude_compare #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .ready       (ready),
    .done        (done),
    .gt          (gt),
    .eq          (eq),
    .lt          (lt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {gt,eq,lt} from whole-word arithmetic
  function automatic logic [2:0] model_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic sm);
    longint sx, sy;
    if (sm) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end
    if (sx > sy) return 3'b100;
    if (sx == sy) return 3'b010;
    return 3'b001;
  endfunction

  // slices examined: up to and including the first differing slice from the top
  function automatic int model_edges(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    for (int s = NSLICE - 1; s >= 0; s--) begin
      if (x[s*SLICE +: SLICE] != y[s*SLICE +: SLICE]) return NSLICE - s;
    end
    return NSLICE;
  endfunction

  // Called at a negedge with the DUT idle.
  task automatic run_cmp(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic tsm, input bit poke);
    logic [2:0] exp_res;
    int         exp_k;
    int         edges;
    int         dones;
    bit         seen;
    exp_res = model_res(ta, tb, tsm);
    exp_k   = model_edges(ta, tb);
    check({tag, " ready_before"}, 64'(ready), 64'(1));
    a = ta;
    b = tb;
    signed_mode = tsm;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    signed_mode = ~tsm;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < NSLICE + 3) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        check({tag, " busy_ready"}, 64'(ready), 64'(0));
        check({tag, " busy_res"}, 64'({gt, eq, lt}), 64'(0));
        if (poke && edges == 1) begin
          start = 1'b1;
          a = ~ta;
          b = ~tb;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check({tag, " done_seen"}, 64'(seen), 64'(1));
    check({tag, " latency"}, 64'(edges), 64'(exp_k));
    check({tag, " result"}, 64'({gt, eq, lt}), 64'(exp_res));
    check({tag, " done_ready"}, 64'(ready), 64'(0));
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check({tag, " ready_after"}, 64'(ready), 64'(1));
    check({tag, " extra_done"}, 64'(dones), 64'(0));
    check({tag, " held"}, 64'({gt, eq, lt}), 64'(exp_res));
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rsm;
    int               dones;
    bit               seen;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset ready", 64'(ready), 64'(1));
    check("reset done", 64'(done), 64'(0));
    check("reset res", 64'({gt, eq, lt}), 64'(0));

    run_cmp("c1 eq", 32'h12345678, 32'h12345678, 1'b0, 1'b0);
    run_cmp("c2 u_gt", 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0);
    run_cmp("c2 s_lt", 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0);
    run_cmp("c3 lt2", 32'h12340000, 32'h1235FFFF, 1'b0, 1'b0);
    run_cmp("c3 gt4", 32'h12345679, 32'h12345678, 1'b0, 1'b0);
    run_cmp("c4 s_gt4", 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0);
    run_cmp("c4 s_gt1", 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_cmp("c5 ignore", 32'h00000001, 32'h00000002, 1'b0, 1'b1);

    // reset on the 2nd BUSY edge
    a = 32'h12345678;
    b = 32'h12345678;
    signed_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("c6 rst ready", 64'(ready), 64'(1));
    check("c6 rst res", 64'({gt, eq, lt}), 64'(0));
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("c6 no_done", 64'(dones), 64'(0));
    run_cmp("c6 fresh", 32'h12345678, 32'h12345678, 1'b0, 1'b0);

    // held start: re-accepted on the edge after DONE
    a = 32'h00000005;
    b = 32'h00000005;
    start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < NSLICE + 3 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("held done", 64'(seen), 64'(1));
    @(negedge clk);
    check("held idle", 64'(ready), 64'(1));
    @(negedge clk);
    check("held reaccept", 64'(ready), 64'(0));
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < NSLICE + 3 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("held done2", 64'(seen), 64'(1));
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      ra  = $urandom;
      rsm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = ra ^ (32'($urandom) & 32'h00FFFFFF);
        2: rb = ra ^ (32'($urandom) & 32'h000000FF);
        default: rb = ra;
      endcase
      run_cmp("rand", ra, rb, rsm, 1'(n % 5 == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
